// File: rtl/ppa_pkg.sv
// ppa_pkg: shared definitions for pipelined_prefix_adder.
//   ppa_side_t  - per-stage side-band (valid bit and effective carry-in)
//   ppa_clog2   - ceil(log2(value)), usable in constant expressions
//   ppa_lat     - pipeline latency in cycles for a given WIDTH / REG_EVERY
//   ppa_black   - prefix black cell, returns {g, p}
//   ppa_grey    - prefix grey cell, returns g only
package ppa_pkg;

    typedef struct packed {
        logic valid;
        logic cin;
    } ppa_side_t;

    function automatic int ppa_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One operand register plus one register per group of REG_EVERY levels;
    // the last group's register doubles as the output register.
    function automatic int ppa_lat(input int width, input int reg_every);
        int levels;
        levels = ppa_clog2(width);
        return 1 + (levels + reg_every - 1) / reg_every;
    endfunction

    function automatic logic [1:0] ppa_black(input logic g_hi, input logic p_hi,
                                             input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

    function automatic logic ppa_grey(input logic g_hi, input logic p_hi, input logic g_lo);
        return g_hi | (p_hi & g_lo);
    endfunction

endpackage

// File: rtl/ppa_prefix_level.sv
// ppa_prefix_level: one level of a Sklansky parallel-prefix tree (pure comb).
// Parameters: WIDTH (vector width), LEVEL (1-based level number).
// Ports:
//   g_i, p_i : group generate/propagate entering the level
//   g_o, p_o : group generate/propagate leaving the level
// Every bit whose index bit (LEVEL-1) is set absorbs the group ending just
// below its 2^(LEVEL-1)-aligned block; all other bits pass through.
module ppa_prefix_level
    import ppa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 1
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);

    localparam int SPAN = 32'sd1 << (LEVEL - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i / SPAN) % 2) == 1) begin : g_black
            localparam int LO = (i / SPAN) * SPAN - 1;
            assign {g_o[i], p_o[i]} = ppa_black(g_i[i], p_i[i], g_i[LO], p_i[LO]);
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: valid/ready pipelined Sklansky adder/subtractor.
// Parameters: WIDTH (8/16/32/64), REG_EVERY (prefix levels per register stage).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = out_ready | ~out_valid)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : result handshake
//   sum, cout           : registered result; for sub=1 cout=1 means no borrow
//   ovf                 : signed overflow, only when PPA_OVERFLOW_EN is defined
// Optional feature macro: PPA_OVERFLOW_EN.
// All stages share one enable, so a stalled output freezes the whole pipe and
// bubbles travel with the data.
module pipelined_prefix_adder
    import ppa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PPA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int LEVELS = ppa_clog2(WIDTH);
    localparam int NSEG   = ppa_lat(WIDTH, REG_EVERY) - 1;

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;

    // Stage s holds the tree state entering segment s (stage 0 = operands).
    logic [WIDTH-1:0] seg_g_d    [0:NSEG-1];
    logic [WIDTH-1:0] seg_g_q    [0:NSEG-1];
    logic [WIDTH-1:0] seg_p_d    [0:NSEG-1];
    logic [WIDTH-1:0] seg_p_q    [0:NSEG-1];
    logic [WIDTH-1:0] seg_po_d   [0:NSEG-1];
    logic [WIDTH-1:0] seg_po_q   [0:NSEG-1];
    ppa_side_t        seg_side_d [0:NSEG-1];
    ppa_side_t        seg_side_q [0:NSEG-1];

    logic [WIDTH-1:0] lvl_in_g  [1:LEVELS];
    logic [WIDTH-1:0] lvl_in_p  [1:LEVELS];
    logic [WIDTH-1:0] lvl_out_g [1:LEVELS];
    logic [WIDTH-1:0] lvl_out_p [1:LEVELS];

    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] unused_top_p_s;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             out_valid_q;

    assign en_s     = out_ready | ~out_valid_q;
    assign in_ready = en_s;

    // Subtraction is a + ~b + 1: invert b and force the carry-in.
    assign b_eff_s               = sub ? ~b : b;
    assign seg_g_d[0]            = a & b_eff_s;
    assign seg_p_d[0]            = a ^ b_eff_s;
    assign seg_po_d[0]           = a ^ b_eff_s;
    assign seg_side_d[0].valid   = in_valid;
    assign seg_side_d[0].cin     = sub | cin;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        if (((k - 1) % REG_EVERY) == 0) begin : g_seg_entry
            if (k == 1) begin : g_cin_fold
                // Carry-in is prefix position -1 (p=0, g=cin) merged into bit 0,
                // so every group below covers the carry-in as well.
                assign lvl_in_g[k] = {seg_g_q[0][WIDTH-1:1],
                                      ppa_grey(seg_g_q[0][0], seg_p_q[0][0], seg_side_q[0].cin)};
                assign lvl_in_p[k] = {seg_p_q[0][WIDTH-1:1], 1'b0};
            end else begin : g_from_reg
                assign lvl_in_g[k] = seg_g_q[(k - 1) / REG_EVERY];
                assign lvl_in_p[k] = seg_p_q[(k - 1) / REG_EVERY];
            end
        end else begin : g_chain
            assign lvl_in_g[k] = lvl_out_g[k - 1];
            assign lvl_in_p[k] = lvl_out_p[k - 1];
        end

        ppa_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (k)
        ) u_level (
            .g_i (lvl_in_g[k]),
            .p_i (lvl_in_p[k]),
            .g_o (lvl_out_g[k]),
            .p_o (lvl_out_p[k])
        );
    end

    for (genvar s = 1; s < NSEG; s++) begin : g_seg_reg
        assign seg_g_d[s]    = lvl_out_g[s * REG_EVERY];
        assign seg_p_d[s]    = lvl_out_p[s * REG_EVERY];
        assign seg_po_d[s]   = seg_po_q[s - 1];
        assign seg_side_d[s] = seg_side_q[s - 1];
    end

    // After the last level, carry_s[i] is the carry out of bit i.
    assign carry_s        = lvl_out_g[LEVELS];
    assign unused_top_p_s = lvl_out_p[LEVELS];
    assign sum_d          = seg_po_q[NSEG-1] ^ {carry_s[WIDTH-2:0], seg_side_q[NSEG-1].cin};
    assign cout_d         = carry_s[WIDTH-1];

    // Pipeline stages and output register, all advancing together on en_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEG; s++) begin
                seg_g_q[s]    <= {WIDTH{1'b0}};
                seg_p_q[s]    <= {WIDTH{1'b0}};
                seg_po_q[s]   <= {WIDTH{1'b0}};
                seg_side_q[s] <= '{valid: 1'b0, cin: 1'b0};
            end
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en_s) begin
            for (int s = 0; s < NSEG; s++) begin
                seg_g_q[s]    <= seg_g_d[s];
                seg_p_q[s]    <= seg_p_d[s];
                seg_po_q[s]   <= seg_po_d[s];
                seg_side_q[s] <= seg_side_d[s];
            end
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= seg_side_q[NSEG-1].valid;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef PPA_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_d = carry_s[WIDTH-2] ^ carry_s[WIDTH-1];

    // Overflow flag register, aligned with sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en_s) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter REG_EVERY, default 2: number of prefix levels between pipeline registers; legal range 1..log2(WIDTH).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operand beat present.
REQ-006 SHALL have port in_ready, output, 1: beat accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port a, input, WIDTH: first operand.
REQ-008 SHALL have port b, input, WIDTH: second operand.
REQ-009 SHALL have port cin, input, 1: carry-in; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1: 0 selects a+b+cin; 1 selects a-b (a + ~b + 1).
REQ-011 SHALL have port out_valid, output, 1: result beat present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port sum, output, WIDTH: result modulo 2^WIDTH.
REQ-014 SHALL have port cout, output, 1: carry out of bit WIDTH-1; for sub=1, 1 means no borrow.

Function
REQ-015 SHALL compute per-bit p=a^b', g=a&b', where b' = sub ? ~b : b, and carry-in = sub ? 1 : cin, injected as prefix position -1 with p=0, g=carry-in.
REQ-016 SHALL use a Sklansky prefix tree with L=log2(WIDTH) levels; at level k, every bit whose index bit (k-1) is set combines with the group ending at the last bit below its 2^(k-1)-aligned block (black cell: g=g_hi|(p_hi&g_lo), p=p_hi&p_lo).
REQ-017 SHALL compute sum[i] = p[i] ^ G[i-1], where G[-1] is the carry-in, and cout = g[W-1] | (p[W-1] & G[W-2]) (grey cell).
REQ-018 SHALL register operands at acceptance, register after every REG_EVERY prefix levels, and register the final outputs; latency LAT = 1 + ceil(L/REG_EVERY) cycles (W16/RE2 -> 3; W16/RE4 -> 2; W64/RE1 -> 7).
REQ-019 SHALL advance all stages together on en = out_ready | ~out_valid; in_ready = en, combinationally.
REQ-020 SHALL hold every stage, including sum, cout and out_valid, unchanged while en=0.
REQ-021 SHALL propagate a per-stage valid bit; bubbles are carried, not collapsed; full throughput is one result per cycle with out_ready held high.
REQ-022 SHALL keep sum/cout stable while out_valid=1 and out_ready=0.

Reset
REQ-023 SHALL, while rst_n=0, force all stage valid bits, out_valid, sum and cout to 0 immediately; in_ready reads 1 after reset.
REQ-024 SHALL discard in-flight beats when reset asserts mid-operation; the first result after release is from the first beat accepted after release.

Configuration
REQ-025 SHALL, with PPA_OVERFLOW_EN defined, add output ovf, 1 bit, reset 0: signed two's-complement overflow = carry into bit W-1 XOR cout, registered and aligned with sum.
REQ-026 SHALL, without PPA_OVERFLOW_EN, have no ovf port and no overflow logic.

Structure
REQ-027 SHALL place black/grey cell functions, a clog2 helper and the LAT computation function in package ppa_pkg.
REQ-028 SHALL implement one prefix level as sub-module ppa_prefix_level (parameters WIDTH, LEVEL), instantiated L times through generate.

Verification
REQ-029 W16/RE2, a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 3 cycles: sum=0x0000, cout=1; ovf=0.
REQ-030 W16, a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1 (macro on); a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0.
REQ-031 W16/RE2, in_valid=1 every cycle, out_ready low for cycles 5-8 -> in_ready low for cycles 5-8, no result lost or duplicated, order preserved.
REQ-032 Reset pulse with 3 beats in flight -> out_valid=0 immediately; no stale result appears after release.
REQ-033 Random 10^5 beats at each of W8/RE1, W32/RE3, W64/RE6 with random valid/ready -> every result equals the reference model; measured latency equals LAT.
